uart_core_param: RTL and testbench

- Parametrised UART transceiver: TX and RX engines plus a shared 16x-oversampling baud tick generator.
- Data width, parity mode and stop-bit count are set by parameters. Baud divisor is a runtime input.
- TX takes bytes over a valid/ready handshake. RX produces words with a one-cycle valid strobe and parity/framing error flags.
- Replaces the fixed 8N1 tx/rx/baud_generator trio in the board-level UART wrapper.

---
 rtl/uart_core_param.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_core_param.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core_param.sv
// uart_core_param: parametrised UART transceiver (TX + RX) sharing a 16x oversampling tick.
// Define UART_LOOPBACK_EN to add a loopback input that feeds the internal tx into RX and parks the tx pin high.
module uart_core_param #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
`ifdef UART_LOOPBACK_EN
  input  logic                 loopback,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);
  localparam int unsigned BCNT_W  = 4;
  localparam logic        HAS_PAR = (PARITY != 0);
  localparam logic        PAR_ODD = (PARITY == 1);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} state_e;

  // Tick generator; a new divisor is picked up only when the counter wraps
  logic [DIV_W-1:0] div_eff_c;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] tick_cnt_q;
  logic             tick_c;

  assign div_eff_c = (baud_div == '0) ? DIV_W'(1) : baud_div;
  assign tick_c    = (tick_cnt_q == div_q - DIV_W'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_cnt_q <= '0;
      div_q      <= div_eff_c;
    end else if (tick_c) begin
      tick_cnt_q <= '0;
      div_q      <= div_eff_c;
    end else begin
      tick_cnt_q <= tick_cnt_q + DIV_W'(1);
    end
  end

  // Transmitter
  state_e                tx_state_q;
  logic [3:0]            tx_tcnt_q;
  logic [BCNT_W-1:0]     tx_bcnt_q;
  logic [DATA_BITS-1:0]  tx_shift_q;
  logic                  tx_par_q;
  logic                  tx_q;
  logic                  tx_ready_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state_q <= ST_IDLE;
      tx_tcnt_q  <= '0;
      tx_bcnt_q  <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
    end else if (tx_state_q == ST_IDLE) begin
      if (tx_valid) begin
        tx_shift_q <= tx_data;
        tx_par_q   <= (^tx_data) ^ PAR_ODD;
        tx_tcnt_q  <= '0;
        tx_state_q <= ST_START;
        tx_q       <= 1'b0;
        tx_ready_q <= 1'b0;
      end
    end else if (tick_c) begin
      tx_tcnt_q <= tx_tcnt_q + 4'd1;
      if (tx_tcnt_q == 4'd15) begin
        case (tx_state_q)
          ST_START: begin
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
            tx_bcnt_q  <= '0;
            tx_state_q <= ST_DATA;
          end
          ST_DATA: begin
            if (tx_bcnt_q == BCNT_W'(DATA_BITS - 1)) begin
              tx_bcnt_q <= '0;
              if (HAS_PAR) begin
                tx_q       <= tx_par_q;
                tx_state_q <= ST_PAR;
              end else begin
                tx_q       <= 1'b1;
                tx_state_q <= ST_STOP;
              end
            end else begin
              tx_bcnt_q  <= tx_bcnt_q + BCNT_W'(1);
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
            end
          end
          ST_PAR: begin
            tx_q       <= 1'b1;
            tx_bcnt_q  <= '0;
            tx_state_q <= ST_STOP;
          end
          ST_STOP: begin
            if (tx_bcnt_q == BCNT_W'(STOP_BITS - 1)) begin
              tx_state_q <= ST_IDLE;
              tx_ready_q <= 1'b1;
            end else begin
              tx_bcnt_q <= tx_bcnt_q + BCNT_W'(1);
            end
          end
          default: tx_state_q <= ST_IDLE;
        endcase
      end
    end
  end

  logic rx_src_c;
`ifdef UART_LOOPBACK_EN
  assign rx_src_c = loopback ? tx_q : rx;
  assign tx       = tx_q | loopback;
`else
  assign rx_src_c = rx;
  assign tx       = tx_q;
`endif

  // Receiver: two-flop synchroniser, then mid-bit sampling on the shared tick
  logic [1:0]           rx_sync_q;
  logic                 rx_s_c;
  state_e               rx_state_q;
  logic [3:0]           rx_tcnt_q;
  logic [BCNT_W-1:0]    rx_bcnt_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_par_q;
  logic                 rx_ferr_acc_q;
  logic                 rx_valid_q;
  logic                 rx_perr_q;
  logic                 rx_ferr_q;
  logic                 rx_mid_c;

  assign rx_s_c   = rx_sync_q[1];
  assign rx_mid_c = tick_c && (rx_tcnt_q == 4'd15);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_sync_q     <= 2'b11;
      rx_state_q    <= ST_IDLE;
      rx_tcnt_q     <= '0;
      rx_bcnt_q     <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_par_q      <= 1'b0;
      rx_ferr_acc_q <= 1'b0;
      rx_valid_q    <= 1'b0;
      rx_perr_q     <= 1'b0;
      rx_ferr_q     <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], rx_src_c};
      rx_valid_q <= 1'b0;
      if (tick_c && (rx_state_q != ST_IDLE)) rx_tcnt_q <= rx_tcnt_q + 4'd1;
      case (rx_state_q)
        ST_IDLE: begin
          if (!rx_s_c) begin
            rx_tcnt_q     <= '0;
            rx_ferr_acc_q <= 1'b0;
            rx_state_q    <= ST_START;
          end
        end
        ST_START: begin
          // line high at the start-bit centre means the falling edge was a glitch
          if (tick_c && (rx_tcnt_q == 4'd7)) begin
            rx_tcnt_q  <= '0;
            rx_bcnt_q  <= '0;
            rx_state_q <= rx_s_c ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (rx_mid_c) begin
            rx_shift_q <= {rx_s_c, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bcnt_q == BCNT_W'(DATA_BITS - 1)) begin
              rx_bcnt_q  <= '0;
              rx_state_q <= HAS_PAR ? ST_PAR : ST_STOP;
            end else begin
              rx_bcnt_q <= rx_bcnt_q + BCNT_W'(1);
            end
          end
        end
        ST_PAR: begin
          if (rx_mid_c) begin
            rx_par_q   <= rx_s_c;
            rx_bcnt_q  <= '0;
            rx_state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (rx_mid_c) begin
            if (rx_bcnt_q == BCNT_W'(STOP_BITS - 1)) begin
              rx_data_q  <= rx_shift_q;
              rx_ferr_q  <= rx_ferr_acc_q | ~rx_s_c;
              rx_perr_q  <= HAS_PAR && (((^rx_shift_q) ^ rx_par_q) != PAR_ODD);
              rx_valid_q <= 1'b1;
              rx_state_q <= ST_IDLE;
            end else begin
              rx_ferr_acc_q <= rx_ferr_acc_q | ~rx_s_c;
              rx_bcnt_q     <= rx_bcnt_q + BCNT_W'(1);
            end
          end
        end
        default: rx_state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_ready      = tx_ready_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: three instances (8N1, 8E1 with tx wired to rx, 8O2) checked against a frame-level model.
module tb_uart_core_param;
  localparam int D0 = 2;
  localparam int D1 = 3;
  localparam int D2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [15:0] bd0, bd1, bd2;
  logic [7:0]  txd0, txd1;
  logic        txv0, txv1;
  logic        txr0, txr1, txr2;
  logic        tx0, tx1, tx2;
  logic        rx0, rx2;
  wire         rx1;
  logic [7:0]  rxd0, rxd1, rxd2;
  logic        rxv0, rxv1, rxv2;
  logic        pe0, pe1, pe2, fe0, fe1, fe2;
`ifdef UART_LOOPBACK_EN
  logic        lb0;
`endif

  assign rx1 = tx1;

  uart_core_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_W(16)) u0 (
    .clk(clk), .reset(rst_n), .baud_div(bd0), .tx_data(txd0), .tx_valid(txv0),
    .tx_ready(txr0), .tx(tx0), .rx(rx0),
`ifdef UART_LOOPBACK_EN
    .loopback(lb0),
`endif
    .rx_data(rxd0), .rx_valid(rxv0), .rx_parity_err(pe0), .rx_frame_err(fe0));

  uart_core_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DIV_W(16)) u1 (
    .clk(clk), .reset(rst_n), .baud_div(bd1), .tx_data(txd1), .tx_valid(txv1),
    .tx_ready(txr1), .tx(tx1), .rx(rx1),
`ifdef UART_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .rx_data(rxd1), .rx_valid(rxv1), .rx_parity_err(pe1), .rx_frame_err(fe1));

  uart_core_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .DIV_W(16)) u2 (
    .clk(clk), .reset(rst_n), .baud_div(bd2), .tx_data(8'h00), .tx_valid(1'b0),
    .tx_ready(txr2), .tx(tx2), .rx(rx2),
`ifdef UART_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .rx_data(rxd2), .rx_valid(rxv2), .rx_parity_err(pe2), .rx_frame_err(fe2));

  // rx_valid pulse counters
  int vc0 = 0, vc1 = 0, vc2 = 0;
  always @(posedge clk) begin
    if (rxv0) vc0 <= vc0 + 1;
    if (rxv1) vc1 <= vc1 + 1;
    if (rxv2) vc2 <= vc2 + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx0 = v;
    else            rx2 = v;
  endtask

  // Drive one frame LSB first; a low final stop bit is cut short so the line idles high before the next sample
  task automatic drive_frame(input int which, input int div, input logic [7:0] d, input bit has_par,
                             input logic pbit, input int nstop, input logic stop_v);
    logic [11:0] bits;
    int n;
    int len;
    bits = '0;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin bits[n] = d[i]; n++; end
    if (has_par) begin bits[n] = pbit; n++; end
    for (int s = 0; s < nstop; s++) begin bits[n] = stop_v; n++; end
    for (int i = 0; i < n; i++) begin
      set_rx(which, bits[i]);
      len = ((i == n - 1) && !bits[i]) ? 12 * div : 16 * div;
      repeat (len) @(negedge clk);
    end
    set_rx(which, 1'b1);
    repeat (64 * div) @(negedge clk);
  endtask

  // Called at the first negedge after a u0 handshake; checks each bit centre and the ready latency
  task automatic capture_tx0(input logic [7:0] d, input string tag);
    logic [9:0] eb;
    int kr;
    eb = {1'b1, d, 1'b0};
    kr = -1;
    check({tag, "_tx_low"}, 32'(tx0), 32'(0));
    check({tag, "_busy"}, 32'(txr0), 32'(0));
    for (int k = 1; k <= 170 * D0; k++) begin
      if (k > 1) @(negedge clk);
      for (int j = 0; j < 10; j++)
        if (k == 16 * D0 * j + 8 * D0)
          check($sformatf("%s_bit%0d", tag, j), 32'(tx0), 32'(eb[j]));
      if (kr < 0 && txr0) kr = k - 1;
    end
    check({tag, "_ready_latency"}, 32'((kr >= 159 * D0 + 1) && (kr <= 160 * D0)), 32'(1));
  endtask

  function automatic logic odd_perr(input logic [7:0] d, input logic pbit);
    return ((($countones(d) + int'(pbit)) % 2) != 1);
  endfunction

  logic [7:0] d8;
  logic       pbit;
  logic       sbit;
  logic       pobs;
  int         base;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bd0 = 16'(D0); bd1 = 16'(D1); bd2 = 16'(D2);
    txd0 = '0; txv0 = 1'b0; txd1 = '0; txv1 = 1'b0;
    rx0 = 1'b1; rx2 = 1'b1;
`ifdef UART_LOOPBACK_EN
    lb0 = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx0), 32'(1));
    check("rst_ready", 32'(txr0), 32'(1));
    check("rst_valid", 32'(rxv0), 32'(0));
    check("rst_rxdata", 32'(rxd0), 32'(0));
    check("rst_perr", 32'(pe0), 32'(0));
    check("rst_ferr", 32'(fe0), 32'(0));
    check("rst_ready_u2", 32'({txr2, tx2, txr1}), 32'(3'b111));
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 transmit of 0xA5
    @(negedge clk); txd0 = 8'hA5; txv0 = 1'b1;
    @(negedge clk); txv0 = 1'b0;
    capture_tx0(8'hA5, "tx_a5");

    // reset mid-frame with tx_valid held high, then a clean frame
    @(negedge clk); txd0 = 8'h96; txv0 = 1'b1;
    @(negedge clk);
    repeat (16 * D0 * 3) @(negedge clk);
    check("rstmid_busy", 32'(txr0), 32'(0));
    txd0 = 8'h3C; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("rstmid_tx_high", 32'(tx0), 32'(1));
    check("rstmid_ready", 32'(txr0), 32'(1));
    @(negedge clk); txv0 = 1'b0;
    capture_tx0(8'h3C, "after_rst");

`ifdef UART_LOOPBACK_EN
    begin : lb_blk
      int zeros;
      zeros = 0;
      base = vc0;
      lb0 = 1'b1;
      @(negedge clk); txd0 = 8'hC3; txv0 = 1'b1;
      @(negedge clk); txv0 = 1'b0;
      for (int k = 0; k < 180 * D0; k++) begin
        if (tx0 !== 1'b1) zeros++;
        @(negedge clk);
      end
      check("lb_pin_high", 32'(zeros), 32'(0));
      check("lb_count", 32'(vc0 - base), 32'(1));
      check("lb_data", 32'(rxd0), 32'(8'hC3));
      lb0 = 1'b0;
      repeat (10) @(negedge clk);
    end
`endif

    // glitch shorter than half a bit is rejected
    base = vc0;
    rx0 = 1'b0;
    repeat (4 * D0) @(negedge clk);
    rx0 = 1'b1;
    repeat (32 * D0) @(negedge clk);
    check("glitch_no_valid", 32'(vc0 - base), 32'(0));

    // u0 receive: fixed frames, then random data and random stop level
    for (int i = 0; i < 6; i++) begin
      d8   = (i == 0) ? 8'h5A : (i == 1) ? 8'hFF : 8'($urandom);
      sbit = (i == 1) ? 1'b0 : (i == 2) ? 1'b1 : 1'($urandom);
      base = vc0;
      drive_frame(0, D0, d8, 1'b0, 1'b0, 1, sbit);
      check($sformatf("rx0_count_%0d", i), 32'(vc0 - base), 32'(1));
      check($sformatf("rx0_data_%0d", i), 32'(rxd0), 32'(d8));
      check($sformatf("rx0_ferr_%0d", i), 32'(fe0), 32'(!sbit));
      check($sformatf("rx0_perr_%0d", i), 32'(pe0), 32'(0));
    end

    // u2 odd parity, two stop bits: fixed parity cases then random
    for (int i = 0; i < 6; i++) begin
      d8   = (i < 2) ? 8'h01 : 8'($urandom);
      pbit = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : 1'($urandom);
      base = vc2;
      drive_frame(2, D2, d8, 1'b1, pbit, 2, 1'b1);
      check($sformatf("rx2_count_%0d", i), 32'(vc2 - base), 32'(1));
      check($sformatf("rx2_data_%0d", i), 32'(rxd2), 32'(d8));
      check($sformatf("rx2_perr_%0d", i), 32'(pe2), 32'(odd_perr(d8, pbit)));
      check($sformatf("rx2_ferr_%0d", i), 32'(fe2), 32'(0));
    end

    // u1 even parity, tx wired to rx
    for (int i = 0; i < 5; i++) begin
      d8   = (i == 0) ? 8'h3C : 8'($urandom);
      base = vc1;
      pobs = 1'bx;
      @(negedge clk); txd1 = d8; txv1 = 1'b1;
      @(negedge clk); txv1 = 1'b0;
      for (int k = 1; k <= 12 * 16 * D1; k++) begin
        if (k == 16 * D1 * 9 + 8 * D1) pobs = tx1;
        @(negedge clk);
      end
      check($sformatf("tx1_parbit_%0d", i), 32'(pobs), 32'(($countones(d8) % 2) == 1));
      check($sformatf("rx1_count_%0d", i), 32'(vc1 - base), 32'(1));
      check($sformatf("rx1_data_%0d", i), 32'(rxd1), 32'(d8));
      check($sformatf("rx1_errs_%0d", i), 32'({pe1, fe1}), 32'(0));
      check($sformatf("tx1_ready_%0d", i), 32'(txr1), 32'(1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
